// File: rtl/gps_ca_checker.sv
// GPS C/A code checker: regenerates the Gold code for the selected PRN, slips it
// until it aligns with the incoming chips, then tracks lock and counts chip errors.
module gps_ca_checker #(
    parameter int WINDOW   = 64,
    parameter int MAX_ERR  = 4,
    parameter int LOSS_ERR = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  prn,
    input  logic        start,
    input  logic        chip_valid,
    input  logic        chip,
    output logic        busy,
    output logic        locked,
    output logic        acq_fail,
    output logic [9:0]  code_phase,
    output logic        epoch,
    output logic [15:0] err_count
);
    localparam int WW = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;
    state_t state, state_next;

    logic [5:0]    prn_q;
    logic [9:0]    g1, g2;
    logic [9:0]    tap_sel;
    logic [WW-1:0] win_cnt, mism, win_next, mism_next;
    logic [9:0]    slip_cnt, slip_next;
    logic          slip_pending;
    logic          prn_bad, local_chip, compare, mismatch, window_done;
    logic          search_ok, loss;

    // G2 phase-select taps (stage numbers 1..10) as a bit mask over g2[9:0]
    function automatic logic [9:0] tap_mask(input logic [5:0] p);
        int a, b;
        a = 1;
        b = 1;
        case (p)
            6'd1:  begin a = 2; b = 6;  end
            6'd2:  begin a = 3; b = 7;  end
            6'd3:  begin a = 4; b = 8;  end
            6'd4:  begin a = 5; b = 9;  end
            6'd5:  begin a = 1; b = 9;  end
            6'd6:  begin a = 2; b = 10; end
            6'd7:  begin a = 1; b = 8;  end
            6'd8:  begin a = 2; b = 9;  end
            6'd9:  begin a = 3; b = 10; end
            6'd10: begin a = 2; b = 3;  end
            6'd11: begin a = 3; b = 4;  end
            6'd12: begin a = 5; b = 6;  end
            6'd13: begin a = 6; b = 7;  end
            6'd14: begin a = 7; b = 8;  end
            6'd15: begin a = 8; b = 9;  end
            6'd16: begin a = 9; b = 10; end
            6'd17: begin a = 1; b = 4;  end
            6'd18: begin a = 2; b = 5;  end
            6'd19: begin a = 3; b = 6;  end
            6'd20: begin a = 4; b = 7;  end
            6'd21: begin a = 5; b = 8;  end
            6'd22: begin a = 6; b = 9;  end
            6'd23: begin a = 1; b = 3;  end
            6'd24: begin a = 4; b = 6;  end
            6'd25: begin a = 5; b = 7;  end
            6'd26: begin a = 6; b = 8;  end
            6'd27: begin a = 7; b = 9;  end
            6'd28: begin a = 8; b = 10; end
            6'd29: begin a = 1; b = 6;  end
            6'd30: begin a = 2; b = 7;  end
            6'd31: begin a = 3; b = 8;  end
            6'd32: begin a = 4; b = 9;  end
            default: begin a = 1; b = 1; end
        endcase
        return (10'd1 << (a - 1)) | (10'd1 << (b - 1));
    endfunction

    assign prn_bad     = (prn == 6'd0) || (prn > 6'd32);
    assign tap_sel     = tap_mask(prn_q);
    assign local_chip  = g1[9] ^ (^(g2 & tap_sel));
    assign compare     = chip_valid && !start &&
                         ((state == SEARCH && !slip_pending) || state == LOCKED);
    assign mismatch    = compare && (chip != local_chip);
    assign win_next    = win_cnt + 1'b1;
    assign mism_next   = mism + {{(WW-1){1'b0}}, mismatch};
    assign window_done = compare && (win_next == WW'(WINDOW));
    assign search_ok   = 32'(mism_next) <= 32'(MAX_ERR);
    assign loss        = 32'(mism_next) > 32'(LOSS_ERR);
    assign slip_next   = slip_cnt + 10'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = prn_bad ? IDLE : SEARCH;
        end else begin
            case (state)
                SEARCH: if (window_done) begin
                    if (search_ok)                 state_next = LOCKED;
                    else if (slip_next == 10'd1023) state_next = IDLE;
                end
                LOCKED: if (window_done && loss) state_next = SEARCH;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        busy   = (state != IDLE);
        locked = (state == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prn_q        <= '0;
            g1           <= 10'h3FF;
            g2           <= 10'h3FF;
            code_phase   <= '0;
            win_cnt      <= '0;
            mism         <= '0;
            slip_cnt     <= '0;
            slip_pending <= 1'b0;
            err_count    <= '0;
            acq_fail     <= 1'b0;
            epoch        <= 1'b0;
        end else begin
            epoch <= compare && (state == LOCKED) && (code_phase == 10'd1022);
            if (start) begin
                prn_q     <= prn;
                err_count <= '0;
                acq_fail  <= prn_bad;
                if (!prn_bad) begin
                    g1           <= 10'h3FF;
                    g2           <= 10'h3FF;
                    code_phase   <= '0;
                    win_cnt      <= '0;
                    mism         <= '0;
                    slip_cnt     <= '0;
                    slip_pending <= 1'b0;
                end
            end else if (chip_valid && state == SEARCH && slip_pending) begin
                // Swallowed chip: local code falls one more chip behind the input
                slip_pending <= 1'b0;
            end else if (compare) begin
                if (code_phase == 10'd1022) begin
                    g1         <= 10'h3FF;
                    g2         <= 10'h3FF;
                    code_phase <= '0;
                end else begin
                    g1         <= {g1[8:0], g1[2] ^ g1[9]};
                    g2         <= {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
                    code_phase <= code_phase + 10'd1;
                end
                if (window_done) begin
                    win_cnt <= '0;
                    mism    <= '0;
                end else begin
                    win_cnt <= win_next;
                    mism    <= mism_next;
                end
                if (state == LOCKED && mismatch && err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
                if (state == SEARCH && window_done && !search_ok) begin
                    slip_pending <= 1'b1;
                    slip_cnt     <= slip_next;
                    if (slip_next == 10'd1023) acq_fail <= 1'b1;
                end
                if (state == LOCKED && window_done && loss) begin
                    slip_cnt     <= '0;
                    slip_pending <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gps_ca_checker.sv
// Bench for gps_ca_checker: reference Gold codes built by the G2-delay method,
// a table of start/reset vectors, and streamed sequences for lock/slip/loss cases.
module tb_gps_ca_checker;
    localparam int W     = 32;
    localparam int MAXE  = 2;
    localparam int LOSSE = 16;

    logic        clk = 1'b0;
    logic        rst, start, chip_valid, chip;
    logic [5:0]  prn;
    logic        busy, locked, acq_fail, epoch;
    logic [9:0]  code_phase;
    logic [15:0] err_count;

    gps_ca_checker #(.WINDOW(W), .MAX_ERR(MAXE), .LOSS_ERR(LOSSE)) dut (
        .clk(clk), .rst(rst), .prn(prn), .start(start), .chip_valid(chip_valid),
        .chip(chip), .busy(busy), .locked(locked), .acq_fail(acq_fail),
        .code_phase(code_phase), .epoch(epoch), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   stream_idx = 0;
    int   epoch_hits = 0;
    int   epoch_idx = -1;
    logic g1s[1023];
    logic g2s[1023];

    typedef struct {
        logic       rst;
        logic       start;
        logic [5:0] prn;
        logic       valid;
        logic       chip;
        logic       busy;
        logic       locked;
        logic       fail;
        int         phase;
    } vec_t;
    vec_t tbl[11];

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_chip(input int d, input int idx);
        return g1s[idx] ^ g2s[(idx + 1023 - d) % 1023];
    endfunction

    task automatic note_epoch(input int idx);
        if (epoch === 1'b1) begin
            epoch_hits++;
            epoch_idx = idx;
        end
    endtask

    task automatic send(input int d, input int n, input int nflip, input bit gaps);
        for (int k = 0; k < n; k++) begin
            chip_valid = 1'b1;
            chip = ref_chip(d, stream_idx) ^ (k < nflip);
            step();
            note_epoch(stream_idx);
            stream_idx = (stream_idx + 1) % 1023;
            if (gaps && (k % 7 == 3)) begin
                chip_valid = 1'b0;
                chip = 1'($urandom_range(0, 1));
                step();
                note_epoch(-1);
            end
        end
        chip_valid = 1'b0;
    endtask

    task automatic send_until(input int d, input int maxn, output int cnt, output bit saw_lock);
        cnt = 0;
        saw_lock = 1'b0;
        while (cnt < maxn && locked !== 1'b1 && acq_fail !== 1'b1) begin
            chip_valid = 1'b1;
            chip = ref_chip(d, stream_idx);
            step();
            stream_idx = (stream_idx + 1) % 1023;
            cnt++;
            if (locked === 1'b1) saw_lock = 1'b1;
        end
        chip_valid = 1'b0;
    endtask

    task automatic do_start(input logic [5:0] p, input logic v, input logic c);
        start = 1'b1;
        prn = p;
        chip_valid = v;
        chip = c;
        step();
        start = 1'b0;
        chip_valid = 1'b0;
    endtask

    initial begin
        logic [9:0] r1, r2, first10;
        int  cnt;
        bit  saw;

        rst = 1'b1; start = 1'b0; prn = '0; chip_valid = 1'b0; chip = 1'b0;
        r1 = 10'h3FF;
        r2 = 10'h3FF;
        for (int i = 0; i < 1023; i++) begin
            g1s[i] = r1[9];
            g2s[i] = r2[9];
            r1 = {r1[8:0], r1[2] ^ r1[9]};
            r2 = {r2[8:0], r2[1] ^ r2[2] ^ r2[5] ^ r2[7] ^ r2[8] ^ r2[9]};
        end
        for (int i = 0; i < 10; i++) first10[9-i] = ref_chip(5, i);
        chk("prn1_first10_octal1440", int'(first10), 'o1440);

        // Reset state
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_acq_fail", int'(acq_fail), 0);
        chk("rst_code_phase", int'(code_phase), 0);
        chk("rst_epoch", int'(epoch), 0);
        chk("rst_err_count", int'(err_count), 0);
        rst = 1'b0;
        step();

        // Start / bad-PRN / restart / reset vectors
        tbl[0]  = '{1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1};
        tbl[1]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1};
        tbl[2]  = '{1'b0, 1'b1, 6'd33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1};
        tbl[3]  = '{1'b0, 1'b1, 6'd63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1};
        tbl[4]  = '{1'b0, 1'b1, 6'd32, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b0, 1'b0, 6'd32, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b0, 1'b0, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2};
        tbl[7]  = '{1'b0, 1'b1, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1};
        tbl[8]  = '{1'b0, 1'b1, 6'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b1, 1'b0, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[10] = '{1'b0, 1'b0, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst;
            start = tbl[i].start;
            prn = tbl[i].prn;
            chip_valid = tbl[i].valid;
            chip = tbl[i].chip;
            step();
            start = 1'b0;
            chip_valid = 1'b0;
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("vec%0d_locked", i), int'(locked), int'(tbl[i].locked));
            chk($sformatf("vec%0d_acq_fail", i), int'(acq_fail), int'(tbl[i].fail));
            if (tbl[i].phase >= 0)
                chk($sformatf("vec%0d_code_phase", i), int'(code_phase), tbl[i].phase);
        end

        // Aligned PRN1 from chip 0; the chip coinciding with start is discarded
        do_start(6'd1, 1'b1, ~ref_chip(5, 0));
        chk("prn1_start_phase", int'(code_phase), 0);
        stream_idx = 0;
        send(5, W - 1, 0, 1'b1);
        chk("prn1_not_locked_before_window", int'(locked), 0);
        chk("prn1_phase_before_window", int'(code_phase), W - 1);
        send(5, 1, 0, 1'b0);
        chk("prn1_locked_after_window", int'(locked), 1);
        chk("prn1_phase_at_lock", int'(code_phase), W);
        send(5, 1023 - W, 0, 1'b1);
        chk("prn1_epoch_hits", epoch_hits, 1);
        chk("prn1_epoch_chip", epoch_idx, 1022);
        chk("prn1_phase_wrap", int'(code_phase), 0);
        chk("prn1_err_clean", int'(err_count), 0);
        chk("prn1_still_locked", int'(locked), 1);

        // Loss of lock: finish the partial window, then 17 flipped chips in one window
        send(5, 1, 0, 1'b0);
        send(5, W - 1, 17, 1'b0);
        chk("loss_locked_mid_window", int'(locked), 1);
        chk("loss_err_mid_window", int'(err_count), 17);
        send(5, 1, 0, 1'b0);
        chk("loss_unlocked", int'(locked), 0);
        chk("loss_busy", int'(busy), 1);
        chk("loss_err_count", int'(err_count), 17);
        send(5, W - 1, 0, 1'b0);
        chk("relock_not_yet", int'(locked), 0);
        send(5, 1, 0, 1'b0);
        chk("relock_locked", int'(locked), 1);
        chk("relock_err_hold", int'(err_count), 17);

        // Asynchronous reset while locked, checked before the next clock edge
        rst = 1'b1;
        #2;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_code_phase", int'(code_phase), 0);
        chk("async_rst_err_count", int'(err_count), 0);
        chk("async_rst_epoch", int'(epoch), 0);
        chk("async_rst_acq_fail", int'(acq_fail), 0);
        step();
        rst = 1'b0;
        step();

        // PRN12 stream starting at chip 300: 723 slips then a clean window
        do_start(6'd12, 1'b0, 1'b0);
        stream_idx = 300;
        send_until(254, 1023 * (W + 1) + 100, cnt, saw);
        chk("prn12_lock_chip_count", cnt, 723 * (W + 1) + W);
        chk("prn12_locked", int'(locked), 1);
        chk("prn12_phase_aligned", (int'(code_phase) - stream_idx + 1023) % 1023, 0);
        chk("prn12_acq_fail", int'(acq_fail), 0);

        // PRN1 search against a PRN2 stream: exhausts all slips
        do_start(6'd1, 1'b0, 1'b0);
        chk("xprn_fail_cleared", int'(acq_fail), 0);
        stream_idx = 0;
        send_until(6, 1023 * (W + 1) + 100, cnt, saw);
        chk("xprn_fail_chip_count", cnt, 1023 * W + 1022);
        chk("xprn_never_locked", int'(saw), 0);
        chk("xprn_acq_fail", int'(acq_fail), 1);
        chk("xprn_idle", int'(busy), 0);
        do_start(6'd1, 1'b0, 1'b0);
        chk("xprn_restart_clears_fail", int'(acq_fail), 0);
        chk("xprn_restart_busy", int'(busy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
